// File: rtl/sdram_pro_read_pkg.sv
// rtl/sdram_pro_read_pkg.sv - SDRAM read worker command and state encodings
package sdram_pro_read_pkg;

    // SDRAM command encodings as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_READ       = 4'b0101;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

    // A10 high on PRECHARGE closes every bank
    localparam logic [12:0] ADDR_PRE_ALL  = 13'h0400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT,
        ST_TRCD,
        ST_RD,
        ST_DATA,
        ST_PRE,
        ST_TRP,
        ST_END
    } rd_state_e;

endpackage

// File: rtl/sdram_pro_read.sv
// rtl/sdram_pro_read.sv - SDRAM read worker: ACTIVE/READ/BURST_STOP/PRECHARGE with data capture
module sdram_pro_read
    import sdram_pro_read_pkg::*;
#(
    parameter int TRCD_CLK = 2,
    parameter int CAS_LAT  = 3,
    parameter int TRP_CLK  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        rd_trig,
    input  logic [23:0] rd_start_addr,
    input  logic [9:0]  rd_burst_len,
    input  logic        rd_en,
    input  logic [15:0] rd_sdram_data,
    output logic        rd_req,
    output logic        rd_busy,
    output logic        rd_end,
    output logic [3:0]  rd_cmd,
    output logic [1:0]  rd_bank,
    output logic [12:0] rd_addr,
    output logic [15:0] rd_data_out,
    output logic        rd_data_valid
);

    localparam logic [2:0] TRCD_LAST = 3'(TRCD_CLK - 1);
    localparam logic [2:0] TRP_LAST  = 3'(TRP_CLK - 1);
    localparam logic [9:0] CAS_W     = 10'(CAS_LAT);

    rd_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [9:0]  dcnt_q, dcnt_d;
    logic [23:0] saddr_q, saddr_d;
    logic [9:0]  len_q, len_d;
    logic        en_q;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        end_q, end_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [1:0]  bank_q, bank_d;
    logic [12:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        en_rise;
    logic [9:0]  data_last;
    logic [9:0]  stop_at;

    // dcnt counts cycles since READ; the last sampled word sits at CAS_LAT+L-1
    assign en_rise   = rd_en && !en_q;
    assign data_last = CAS_W + len_q - 10'd1;
    assign stop_at   = len_q - 10'd1;

    // Next-state and registered-output computation; commands are chosen for the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        saddr_d = saddr_q;
        len_d   = len_q;
        req_d   = req_q;
        busy_d  = busy_q;
        end_d   = 1'b0;
        cmd_d   = CMD_NOP;
        bank_d  = bank_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_rise) begin
                    state_d = ST_ACT;
                    cmd_d   = CMD_ACTIVE;
                    bank_d  = saddr_q[23:22];
                    addr_d  = saddr_q[21:9];
                    req_d   = 1'b0;
                    busy_d  = 1'b1;
                end else if (rd_trig && init_end && !busy_q) begin
                    saddr_d = rd_start_addr;
                    len_d   = (rd_burst_len == 10'd0) ? 10'd1 : rd_burst_len;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_ACT: begin
                state_d = ST_TRCD;
                cnt_d   = 3'd0;
            end
            ST_TRCD: begin
                if (cnt_q == TRCD_LAST) begin
                    state_d = ST_RD;
                    cmd_d   = CMD_READ;
                    addr_d  = {4'b0000, saddr_q[8:0]};
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RD: begin
                state_d = ST_DATA;
                dcnt_d  = 10'd1;
                // A single-word burst must be stopped on the very next cycle
                if (len_q == 10'd1) begin
                    cmd_d = CMD_BURST_STOP;
                end
            end
            ST_DATA: begin
                if (dcnt_q == stop_at) begin
                    cmd_d = CMD_BURST_STOP;
                end
                if (dcnt_q >= CAS_W && dcnt_q <= data_last) begin
                    data_d  = rd_sdram_data;
                    valid_d = 1'b1;
                end
                if (dcnt_q == data_last) begin
                    state_d = ST_PRE;
                    cmd_d   = CMD_PRECHARGE;
                    addr_d  = ADDR_PRE_ALL;
                end else begin
                    dcnt_d = dcnt_q + 10'd1;
                end
            end
            ST_PRE: begin
                state_d = ST_TRP;
                cnt_d   = 3'd0;
            end
            ST_TRP: begin
                if (cnt_q == TRP_LAST) begin
                    state_d = ST_END;
                    end_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and all outputs registered; reset abandons any sequence without PRECHARGE
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            dcnt_q  <= 10'd0;
            saddr_q <= 24'd0;
            len_q   <= 10'd1;
            en_q    <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            bank_q  <= 2'd0;
            addr_q  <= 13'd0;
            data_q  <= 16'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            saddr_q <= saddr_d;
            len_q   <= len_d;
            en_q    <= rd_en;
            req_q   <= req_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
            cmd_q   <= cmd_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rd_req        = req_q;
    assign rd_busy       = busy_q;
    assign rd_end        = end_q;
    assign rd_cmd        = cmd_q;
    assign rd_bank       = bank_q;
    assign rd_addr       = addr_q;
    assign rd_data_out   = data_q;
    assign rd_data_valid = valid_q;

endmodule

// File: tb/tb_sdram_pro_read.sv
// tb/tb_sdram_pro_read.sv - directed scoreboard bench for sdram_pro_read
module tb_sdram_pro_read;
    import sdram_pro_read_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        rd_trig = 1'b0;
    logic [23:0] rd_start_addr = 24'd0;
    logic [9:0]  rd_burst_len = 10'd0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_sdram_data;
    logic        rd_req, rd_busy, rd_end, rd_data_valid;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_bank;
    logic [12:0] rd_addr;
    logic [15:0] rd_data_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {int c; logic [3:0] cmd; logic [1:0] bank; logic [12:0] addr;} cmd_t;
    typedef struct {int c; logic [15:0] d;} dat_t;
    cmd_t cmdq[$];
    dat_t datq[$];

    sdram_pro_read dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
        .rd_trig(rd_trig), .rd_start_addr(rd_start_addr), .rd_burst_len(rd_burst_len),
        .rd_en(rd_en), .rd_sdram_data(rd_sdram_data), .rd_req(rd_req), .rd_busy(rd_busy),
        .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_data_out(rd_data_out), .rd_data_valid(rd_data_valid)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // SDRAM model: the word on DQ during cycle n is a fixed hash of n
    function automatic logic [15:0] gen(input int c);
        return 16'(c * 40503 + 4660);
    endfunction
    assign rd_sdram_data = gen(cyc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, rd_req, 1'b0);
        chk({tag, "_busy"}, rd_busy, 1'b0);
        chk({tag, "_end"}, rd_end, 1'b0);
        chk({tag, "_cmd"}, rd_cmd, CMD_NOP);
        chk({tag, "_bank"}, rd_bank, 2'd0);
        chk({tag, "_addr"}, rd_addr, 13'd0);
        chk({tag, "_dout"}, rd_data_out, 16'd0);
        chk({tag, "_valid"}, rd_data_valid, 1'b0);
    endtask

    task automatic trigger(input logic [23:0] a, input logic [9:0] len);
        @(posedge sys_clk); #1;
        rd_trig = 1'b1; rd_start_addr = a; rd_burst_len = len;
        @(posedge sys_clk); #1;
        rd_trig = 1'b0; rd_start_addr = 24'd0; rd_burst_len = 10'd0;
    endtask

    // One full read; trig_at >= 0 injects an extra rd_trig during cycle t0+trig_at
    task automatic run_read(input logic [23:0] a, input logic [9:0] len, input int trig_at);
        int L, t0, tr, end_c, e_seen;
        bit req_hi;
        cmd_t c;
        dat_t d;
        L = (len == 10'd0) ? 1 : int'(len);
        trigger(a, len);
        chk("req_set", rd_req, 1'b1);
        chk("busy_set", rd_busy, 1'b1);
        @(posedge sys_clk); #1;
        rd_en = 1'b1;
        t0 = cyc;
        tr = t0 + 4;
        end_c = tr + 3 + L + 3;
        cmdq.push_back('{t0 + 1, CMD_ACTIVE, a[23:22], a[21:9]});
        cmdq.push_back('{tr, CMD_READ, a[23:22], {4'b0000, a[8:0]}});
        cmdq.push_back('{tr + L, CMD_BURST_STOP, a[23:22], {4'b0000, a[8:0]}});
        cmdq.push_back('{tr + 3 + L, CMD_PRECHARGE, a[23:22], 13'h0400});
        for (int k = 0; k < L; k++) datq.push_back('{tr + 4 + k, gen(tr + 3 + k)});
        e_seen = -1;
        req_hi = 1'b0;
        while (cyc < end_c + 4) begin
            @(negedge sys_clk);
            if (cyc >= t0 + 1 && rd_req) req_hi = 1'b1;
            if (trig_at >= 0) begin
                if (cyc == t0 + trig_at) begin
                    rd_trig = 1'b1; rd_start_addr = 24'hFFFFFF; rd_burst_len = 10'd7;
                end else begin
                    rd_trig = 1'b0;
                end
            end
            if (rd_cmd !== CMD_NOP) begin
                if (cmdq.size() == 0) begin
                    chk("extra_cmd", rd_cmd, CMD_NOP);
                end else begin
                    c = cmdq.pop_front();
                    chk("cmd_cycle", cyc - t0, c.c - t0);
                    chk("cmd", rd_cmd, c.cmd);
                    chk("cmd_bank", rd_bank, c.bank);
                    chk("cmd_addr", rd_addr, c.addr);
                end
            end
            if (rd_data_valid) begin
                if (datq.size() == 0) begin
                    chk("extra_valid", rd_data_valid, 1'b0);
                end else begin
                    d = datq.pop_front();
                    chk("data_cycle", cyc - t0, d.c - t0);
                    chk("data", rd_data_out, d.d);
                end
            end
            if (rd_end) begin
                chk("end_cycle", cyc - t0, end_c - t0);
                chk("busy_at_end", rd_busy, 1'b1);
                e_seen = cyc;
            end
            if (e_seen >= 0 && cyc == e_seen + 1) chk("busy_after_end", rd_busy, 1'b0);
            if (e_seen >= 0 && cyc == e_seen + 2) rd_en = 1'b0;
        end
        rd_en = 1'b0;
        rd_trig = 1'b0;
        rd_start_addr = 24'd0;
        rd_burst_len = 10'd0;
        chk("end_seen", e_seen >= 0, 1'b1);
        chk("cmdq_empty", cmdq.size(), 0);
        chk("datq_empty", datq.size(), 0);
        chk("req_low_from_T1", req_hi, 1'b0);
        repeat (2) @(posedge sys_clk);
        #1;
        chk("req_idle", rd_req, 1'b0);
        chk("busy_idle", rd_busy, 1'b0);
        cmdq.delete();
        datq.delete();
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // rd_trig before init_end is dropped
        trigger(24'h123456, 10'd4);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("noinit_req", rd_req, 1'b0);
        chk("noinit_busy", rd_busy, 1'b0);
        chk("noinit_cmd", rd_cmd, CMD_NOP);
        init_end = 1'b1;

        run_read(24'h123456, 10'd4, -1);
        run_read(24'hC00A10, 10'd1, 6);
        run_read(24'h7FFE00, 10'd512, -1);
        run_read(24'h401234, 10'd0, 11);
        run_read(24'h8ABCDE, 10'd4, 14);

        // Reset during the data phase abandons the sequence
        trigger(24'h5A5A5A, 10'd8);
        @(posedge sys_clk); #1;
        rd_en = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge sys_clk); #1;
        chk_reset_outputs("midrst_edge");
        @(negedge sys_clk);
        rd_en = 1'b0;
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("post_rst_cmd", rd_cmd, CMD_NOP);
        run_read(24'h123456, 10'd4, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
